// File: rtl/iir_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : iir_out_buffer
//  Description : Output stage for iir_filter. Captures the backpressure-free
//                dOut/vOut sample stream into a first-word-fall-through FIFO,
//                re-presents it as a valid/ready stream, flags dropped
//                samples (sticky overflow) and counts accepted samples.
//  Revision    : 1.0  initial release
// ============================================================================
module iir_out_buffer #(
  parameter int NB    = 12,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vIn,
  input  logic [NB-1:0] dIn,
  output logic [NB-1:0] dOut,
  output logic          vOut,
  input  logic          ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [CW-1:0] smp_cnt
);

  localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

  logic [NB-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          ovf_q,    ovf_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_full;

  // Head valid and data come only from registered state, so there is no
  // combinational path from vIn/dIn/ready to the consumer-facing outputs.
  assign vOut     = (level_q != '0);
  assign dOut     = vOut ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign smp_cnt  = cnt_q;

  // Handshake decode and next-state computation for pointers, level, flags.
  always_comb begin
    w_full   = (level_q == C_FULL_LVL);
    w_pop    = vOut & ready;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    w_push   = vIn & (~w_full | w_pop);
    w_drop   = vIn & w_full & ~w_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;   // power-of-two depth: wraps naturally
      cnt_d    = cnt_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_push && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (w_pop && !w_push) begin
      level_d = level_q - 1'b1;
    end

    // Clear first so that a drop in the same cycle wins.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (w_drop) begin
      ovf_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sample storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      mem_q[wr_ptr_q] <= dIn;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iir_out_buffer
//  Description : Directed self-checking bench for iir_out_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iir_out_buffer;

  localparam int NB    = 12;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vIn;
  logic [NB-1:0] dIn;
  logic [NB-1:0] dOut;
  logic          vOut;
  logic          ready;
  logic [AW:0]   level;
  logic          overflow;
  logic          clr_ovf;
  logic [CW-1:0] smp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  iir_out_buffer #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .vIn      (vIn),
    .dIn      (dIn),
    .dOut     (dOut),
    .vOut     (vOut),
    .ready    (ready),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .smp_cnt  (smp_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vIn = 1'b0; dIn = '0; ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Push 1..8 with the consumer stalled, leaving the FIFO full.
  task automatic fill_stalled();
    ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      vIn = 1'b1; dIn = NB'(i);
      tick();
    end
    vIn = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (dOut !== 12'h000) begin n_fail++; $display("FAIL reset_dOut got=%h exp=%h", dOut, 12'h000); end
    n_checks++; if (vOut !== 1'b0) begin n_fail++; $display("FAIL reset_vOut got=%b exp=0", vOut); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (smp_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_smp_cnt got=%0d exp=0", smp_cnt); end
  endtask

  task automatic test_pass_through();
    logic [NB-1:0] vals [3];
    vals[0] = 12'h7FF; vals[1] = 12'h800; vals[2] = 12'h001;
    do_reset();
    ready = 1'b1;
    // Empty + ready: nothing changes.
    tick();
    n_checks++; if (vOut !== 1'b0) begin n_fail++; $display("FAIL pt_empty_vOut got=%b exp=0", vOut); end
    for (int i = 0; i < 3; i++) begin
      vIn = 1'b1; dIn = vals[i];
      tick();
      n_checks++; if (vOut !== 1'b1) begin n_fail++; $display("FAIL pt_vOut[%0d] got=%b exp=1", i, vOut); end
      n_checks++; if (dOut !== vals[i]) begin n_fail++; $display("FAIL pt_dOut[%0d] got=%h exp=%h", i, dOut, vals[i]); end
      n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL pt_level[%0d] got=%0d exp=1", i, level); end
    end
    vIn = 1'b0;
    tick();
    n_checks++; if (vOut !== 1'b0) begin n_fail++; $display("FAIL pt_drain_vOut got=%b exp=0", vOut); end
    n_checks++; if (dOut !== 12'h000) begin n_fail++; $display("FAIL pt_drain_dOut got=%h exp=000", dOut); end
    n_checks++; if (smp_cnt !== 16'd3) begin n_fail++; $display("FAIL pt_smp_cnt got=%0d exp=3", smp_cnt); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    fill_stalled();
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fd_level_full got=%0d exp=8", level); end
    n_checks++; if (dOut !== 12'd1) begin n_fail++; $display("FAIL fd_head got=%h exp=001", dOut); end
    vIn = 1'b1; dIn = 12'd9;
    tick();
    vIn = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fd_overflow got=%b exp=1", overflow); end
    n_checks++; if (smp_cnt !== 16'd8) begin n_fail++; $display("FAIL fd_smp_cnt got=%0d exp=8", smp_cnt); end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fd_level_drop got=%0d exp=8", level); end
    ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      n_checks++; if (vOut !== 1'b1 || dOut !== NB'(i)) begin n_fail++; $display("FAIL fd_drain[%0d] got=%b/%h exp=1/%h", i, vOut, dOut, NB'(i)); end
      tick();
    end
    n_checks++; if (vOut !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL fd_empty got=%b/%0d exp=0/0", vOut, level); end
  endtask

  task automatic test_full_push_pop();
    logic [NB-1:0] exp_v;
    do_reset();
    fill_stalled();
    ready = 1'b1; vIn = 1'b1; dIn = 12'h123;
    tick();
    vIn = 1'b0;
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fpp_level got=%0d exp=8", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    n_checks++; if (smp_cnt !== 16'd9) begin n_fail++; $display("FAIL fpp_smp_cnt got=%0d exp=9", smp_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      exp_v = (i == DEPTH - 1) ? 12'h123 : NB'(i + 2);
      n_checks++; if (vOut !== 1'b1 || dOut !== exp_v) begin n_fail++; $display("FAIL fpp_out[%0d] got=%b/%h exp=1/%h", i, vOut, dOut, exp_v); end
      tick();
    end
    n_checks++; if (vOut !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got=%b exp=0", vOut); end
  endtask

  task automatic test_ready_toggle();
    do_reset();
    vIn = 1'b1; dIn = 12'hA5A; tick();
    dIn = 12'h5A5; tick();
    vIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ready = 1'b0; tick();
      n_checks++; if (dOut !== 12'hA5A) begin n_fail++; $display("FAIL rt_hold[%0d] got=%h exp=A5A", i, dOut); end
    end
    ready = 1'b1; tick();
    ready = 1'b0;
    n_checks++; if (dOut !== 12'h5A5 || level !== 4'd1) begin n_fail++; $display("FAIL rt_next got=%h/%0d exp=5A5/1", dOut, level); end
  endtask

  task automatic test_ovf_clear();
    do_reset();
    fill_stalled();
    clr_ovf = 1'b1; vIn = 1'b1; dIn = 12'h055;
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovc_race got=%b exp=1", overflow); end
    n_checks++; if (smp_cnt !== 16'd8) begin n_fail++; $display("FAIL ovc_smp_cnt got=%0d exp=8", smp_cnt); end
    vIn = 1'b0;
    tick();
    clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovc_clear got=%b exp=0", overflow); end
    n_checks++; if (dOut !== 12'd1 || level !== 4'd8) begin n_fail++; $display("FAIL ovc_state got=%h/%0d exp=001/8", dOut, level); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vIn = 1'b1; dIn = NB'(12'h010 + i); tick();
    end
    vIn = 1'b0;
    n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL rm_level5 got=%0d exp=5", level); end
    rst = 1'b1; ready = 1'b1; tick();
    rst = 1'b0; ready = 1'b0;
    n_checks++; if (level !== 4'd0 || vOut !== 1'b0) begin n_fail++; $display("FAIL rm_cleared got=%0d/%b exp=0/0", level, vOut); end
    n_checks++; if (smp_cnt !== 16'd0 || dOut !== 12'h000) begin n_fail++; $display("FAIL rm_cnt_dout got=%0d/%h exp=0/000", smp_cnt, dOut); end
    vIn = 1'b1; dIn = 12'h0AA; tick();
    vIn = 1'b0;
    n_checks++; if (dOut !== 12'h0AA || level !== 4'd1) begin n_fail++; $display("FAIL rm_first got=%h/%0d exp=0AA/1", dOut, level); end
    ready = 1'b1; tick();
    n_checks++; if (vOut !== 1'b0) begin n_fail++; $display("FAIL rm_nostale got=%b exp=0", vOut); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pass_through();
    test_fill_drain();
    test_full_push_pop();
    test_ready_toggle();
    test_ovf_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
